// File: rtl/instr_encode_loader_pkg.sv
// Shared constants for the instruction loader: opcodes, descriptor classes, imm formats, FSM states.
// Optional immediate range checking is enabled by defining IMM_CHECK_EN.
package instr_encode_loader_pkg;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] CL_LW   = 3'd0;
    localparam logic [2:0] CL_SW   = 3'd1;
    localparam logic [2:0] CL_R    = 3'd2;
    localparam logic [2:0] CL_BEQ  = 3'd3;
    localparam logic [2:0] CL_ADDI = 3'd4;
    localparam logic [2:0] CL_JAL  = 3'd5;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // True when every bit from msb upward is a copy of the sign, i.e. the value fits signed msb+1 bits.
    function automatic logic fits_signed(input logic [20:0] imm, input int msb);
        logic r_all1;
        logic r_all0;
        r_all1 = 1'b1;
        r_all0 = 1'b1;
        for (int i = 0; i < 21; i++) begin
            if (i >= msb) begin
                r_all1 = r_all1 & imm[i];
                r_all0 = r_all0 & ~imm[i];
            end
        end
        return r_all1 | r_all0;
    endfunction

endpackage

// File: rtl/instr_encode_loader_field_packer.sv
// Combinational encoder: descriptor class + fields -> RV32I word and an illegal flag.
// With IMM_CHECK_EN defined, out-of-range or misaligned immediates are also flagged illegal.
module instr_field_packer
    import instr_encode_loader_pkg::*;
(
    input  logic [2:0]  i_class,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic        i_f7b5,
    input  logic [20:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic       w_is_r;
    logic       w_bad_class;
    logic       w_imm_bad;
    imm_src_e   w_src;

    always_comb begin
        w_op        = OP_ADDI;
        w_f3        = i_funct3;
        w_is_r      = 1'b0;
        w_bad_class = 1'b0;
        w_src       = IMM_I;
        case (i_class)
            CL_LW:   begin w_op = OP_LW;   w_f3 = 3'b010; w_src = IMM_I; end
            CL_SW:   begin w_op = OP_SW;   w_f3 = 3'b010; w_src = IMM_S; end
            CL_R:    begin w_op = OP_R;    w_is_r = 1'b1; end
            CL_BEQ:  begin w_op = OP_BEQ;  w_f3 = 3'b000; w_src = IMM_B; end
            CL_ADDI: begin w_op = OP_ADDI; w_src = IMM_I; end
            CL_JAL:  begin w_op = OP_JAL;  w_src = IMM_J; end
            default: w_bad_class = 1'b1;
        endcase
    end

`ifdef IMM_CHECK_EN
    always_comb begin
        w_imm_bad = 1'b0;
        if (!w_is_r && !w_bad_class) begin
            case (w_src)
                IMM_I, IMM_S: w_imm_bad = !fits_signed(i_imm, 11);
                IMM_B:        w_imm_bad = !fits_signed(i_imm, 12) || i_imm[0];
                IMM_J:        w_imm_bad = i_imm[0];
                default:      w_imm_bad = 1'b0;
            endcase
        end
    end
`else
    logic w_unused_imm0;
    assign w_imm_bad     = 1'b0;
    assign w_unused_imm0 = i_imm[0];
`endif

    always_comb begin
        o_word    = '0;
        o_illegal = w_bad_class | w_imm_bad;
        if (!o_illegal) begin
            if (w_is_r) begin
                o_word = {1'b0, i_f7b5, 5'b00000, i_rs2, i_rs1, w_f3, i_rd, w_op};
            end else begin
                case (w_src)
                    IMM_I: o_word = {i_imm[11:0], i_rs1, w_f3, i_rd, w_op};
                    IMM_S: o_word = {i_imm[11:5], i_rs2, i_rs1, w_f3, i_imm[4:0], w_op};
                    IMM_B: o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, w_f3,
                                     i_imm[4:1], i_imm[11], w_op};
                    IMM_J: o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, w_op};
                    default: o_word = '0;
                endcase
            end
        end
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Loads encoded descriptors into imem one word per accept, one-cycle write latency.
// Build option IMM_CHECK_EN (in instr_field_packer) adds immediate range checking.
//   state   | meaning
//   IDLE    | after reset, no session open
//   LOAD    | session open, descriptors accepted while room remains
//   DONE    | session closed, core may run
module instr_encode_loader
    import instr_encode_loader_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load_start,
    input  logic              i_load_end,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [2:0]        i_in_class,
    input  logic [4:0]        i_in_rd,
    input  logic [4:0]        i_in_rs1,
    input  logic [4:0]        i_in_rs2,
    input  logic [2:0]        i_in_funct3,
    input  logic              i_in_f7b5,
    input  logic [20:0]       i_in_imm,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_done,
    output logic              o_err_illegal
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    state_e            r_state, w_state_nx;
    logic              r_pend;
    logic              r_end_req;
    logic              r_err;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   w_used;
    logic [31:0]       w_word;
    logic              w_illegal;
    logic              w_open;
    logic              w_accept;
    logic              w_in_load;

    instr_field_packer u_packer (
        .i_class   (i_in_class),
        .i_rd      (i_in_rd),
        .i_rs1     (i_in_rs1),
        .i_rs2     (i_in_rs2),
        .i_funct3  (i_in_funct3),
        .i_f7b5    (i_in_f7b5),
        .i_imm     (i_in_imm),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: if (i_load_start) w_state_nx = ST_LOAD;
            ST_LOAD: if ((i_load_end || r_end_req) && !r_pend) w_state_nx = ST_DONE;
            ST_DONE: if (i_load_start) w_state_nx = ST_LOAD;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    assign w_in_load  = (r_state == ST_LOAD);
    assign w_open     = i_load_start && !w_in_load;
    assign w_used     = r_count + {{ADDR_W{1'b0}}, r_pend};
    assign o_in_ready = w_in_load && (w_used < DEPTH_C) && !i_load_end && !r_end_req;
    assign w_accept   = i_in_valid && o_in_ready;

    // A load_end pulse that lands on a pending write is remembered until the write drains.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend    <= 1'b0;
            r_end_req <= 1'b0;
            r_err     <= 1'b0;
            r_wdata   <= '0;
            r_ptr     <= BASE_C;
            r_count   <= '0;
        end else if (w_open) begin
            r_pend    <= 1'b0;
            r_end_req <= 1'b0;
            r_err     <= 1'b0;
            r_ptr     <= BASE_C;
            r_count   <= '0;
        end else begin
            r_pend    <= w_accept && !w_illegal;
            r_end_req <= w_in_load && (i_load_end || r_end_req) && r_pend;
            if (w_accept && !w_illegal) r_wdata <= w_word;
            if (w_accept && w_illegal)  r_err   <= 1'b1;
            if (r_pend) begin
                r_ptr   <= r_ptr + ADDR_W'(1);
                r_count <= r_count + (ADDR_W+1)'(1);
            end
        end
    end

    assign o_imem_we     = r_pend;
    assign o_imem_addr   = r_pend ? r_ptr : '0;
    assign o_imem_wdata  = r_wdata;
    assign o_count       = r_count;
    assign o_full        = (r_count == DEPTH_C);
    assign o_done        = (r_state == ST_DONE);
    assign o_err_illegal = r_err;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader: table of encoding vectors driven through a write scoreboard,
// plus sequences for illegal class, session close, reset mid-session and a DEPTH=4 fill.
module tb_instr_encode_loader;

    typedef struct {
        logic [2:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        f7b5;
        logic [20:0] imm;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] word;
    } exp_t;

`ifdef IMM_CHECK_EN
    localparam bit IMM_CHK = 1'b1;
`else
    localparam bit IMM_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start, load_end, in_valid, in_f7b5;
    logic [2:0]  in_class, in_funct3;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [20:0] in_imm;
    logic        in_ready, imem_we, full, done, err_illegal;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [6:0]  count;

    logic        d4_load_start, d4_load_end, d4_valid;
    logic [4:0]  d4_rd;
    logic [20:0] d4_imm;
    logic        d4_ready, d4_we, d4_full, d4_done, d4_err;
    logic [5:0]  d4_addr;
    logic [31:0] d4_wdata;
    logic [6:0]  d4_count;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   run = 0;
    int   last_run = 0;
    int   n_w4 = 0;
    exp_t q[$];
    exp_t q4[$];
    vec_t vecs[6];
    vec_t v_r1, v_bad, v_trunc;

    always #5 clk = ~clk;

    instr_encode_loader #(.ADDR_W(6), .DEPTH(64), .BASE_ADDR(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_load_start(load_start), .i_load_end(load_end),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_class(in_class),
        .i_in_rd(in_rd), .i_in_rs1(in_rs1), .i_in_rs2(in_rs2), .i_in_funct3(in_funct3),
        .i_in_f7b5(in_f7b5), .i_in_imm(in_imm), .o_imem_we(imem_we), .o_imem_addr(imem_addr),
        .o_imem_wdata(imem_wdata), .o_count(count), .o_full(full), .o_done(done),
        .o_err_illegal(err_illegal)
    );

    instr_encode_loader #(.ADDR_W(6), .DEPTH(4), .BASE_ADDR(0)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_load_start(d4_load_start), .i_load_end(d4_load_end),
        .i_in_valid(d4_valid), .o_in_ready(d4_ready), .i_in_class(3'd4),
        .i_in_rd(d4_rd), .i_in_rs1(5'd0), .i_in_rs2(5'd0), .i_in_funct3(3'd0),
        .i_in_f7b5(1'b0), .i_in_imm(d4_imm), .o_imem_we(d4_we), .o_imem_addr(d4_addr),
        .o_imem_wdata(d4_wdata), .o_count(d4_count), .o_full(d4_full), .o_done(d4_done),
        .o_err_illegal(d4_err)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (imem_we) begin
            run++;
            if (q.size() == 0) chk("unexpected_write", {26'd0, imem_addr}, 32'hFFFF_FFFF);
            else begin
                e = q.pop_front();
                chk("wr_addr", {26'd0, imem_addr}, {26'd0, e.addr});
                chk("wr_data", imem_wdata, e.word);
            end
        end else begin
            if (run != 0) last_run = run;
            run = 0;
        end
        if (d4_we) begin
            n_w4++;
            if (q4.size() == 0) chk("d4_unexpected_write", {26'd0, d4_addr}, 32'hFFFF_FFFF);
            else begin
                e = q4.pop_front();
                chk("d4_wr_addr", {26'd0, d4_addr}, {26'd0, e.addr});
                chk("d4_wr_data", d4_wdata, e.word);
            end
        end
    end

    task automatic send(input vec_t v, input bit legal, input logic [5:0] addr);
        bit ok;
        ok        = 1'b0;
        in_class  = v.cls;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_funct3 = v.f3;
        in_f7b5   = v.f7b5;
        in_imm    = v.imm;
        in_valid  = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                if (legal) q.push_back('{addr, v.word});
            end
            step();
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && q.size() != 0; i++) step();
        chk("drain_empty", q.size(), 0);
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        vecs[0] = '{3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd5,        32'h0050_0093};
        vecs[1] = '{3'd0, 5'd2, 5'd1, 5'd0, 3'd0, 1'b0, 21'd8,        32'h0080_A103};
        vecs[2] = '{3'd1, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 21'd4,        32'h0020_A223};
        vecs[3] = '{3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 21'd0,        32'h0020_81B3};
        vecs[4] = '{3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 21'h1F_FFF8,  32'hFE20_8CE3};
        vecs[5] = '{3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd16,       32'h0100_00EF};
        v_r1    = '{3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 21'd0,        32'h4020_81B3};
        v_bad   = '{3'd7, 5'd9, 5'd9, 5'd9, 3'd0, 1'b0, 21'd0,        32'h0000_0000};
        v_trunc = '{3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'h0_1005,   32'h0050_0093};

        rst = 1'b1; load_start = 0; load_end = 0; in_valid = 0;
        in_class = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_funct3 = 0; in_f7b5 = 0; in_imm = 0;
        d4_load_start = 0; d4_load_end = 0; d4_valid = 0; d4_rd = 0; d4_imm = 0;
        step(); step();
        chk("rst_ready", in_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_illegal, 0);
        rst = 1'b0;
        step();

        load_start = 1'b1; step(); load_start = 1'b0;
        chk("load_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) send(vecs[i], 1'b1, 6'(i));
        in_valid = 1'b0;
        drain();
        chk("burst_run", last_run, 6);
        chk("burst_count", count, 6);

        send(v_r1, 1'b1, 6'd6);
        send(v_bad, 1'b0, 6'd0);
        send(vecs[0], 1'b1, 6'd7);
        in_valid = 1'b0;
        drain();
        chk("illegal_err", err_illegal, 1);
        chk("illegal_count", count, 8);

        load_end = 1'b1; #1;
        chk("end_ready_mask", in_ready, 0);
        step(); load_end = 1'b0;
        chk("end_done", done, 1);
        chk("end_count", count, 8);
        chk("done_ready", in_ready, 0);

        load_start = 1'b1; step(); load_start = 1'b0;
        chk("reopen_err", err_illegal, 0);
        chk("reopen_count", count, 0);
        chk("reopen_done", done, 0);
        send(v_trunc, !IMM_CHK, 6'd0);
        send(vecs[1], 1'b1, IMM_CHK ? 6'd0 : 6'd1);
        in_valid = 1'b0; load_end = 1'b1;
        step(); load_end = 1'b0;
        chk("drain_wait_done", done, 0);
        step();
        chk("s2_done", done, 1);
        chk("s2_count", count, IMM_CHK ? 1 : 2);
        chk("s2_err", err_illegal, IMM_CHK ? 1 : 0);
        chk("s2_q_empty", q.size(), 0);

        load_start = 1'b1; step(); load_start = 1'b0;
        send(vecs[5], 1'b1, 6'd0);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("midrst_we", imem_we, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ready", in_ready, 0);
        chk("midrst_count", count, 0);
        rst = 1'b0;
        step();
        chk("midrst_q_empty", q.size(), 0);

        d4_load_start = 1'b1; step(); d4_load_start = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            d4_rd    = 5'(acc);
            d4_imm   = 21'(acc);
            d4_valid = 1'b1;
            @(negedge clk);
            if (d4_ready) begin
                q4.push_back('{6'(acc), {12'(acc), 5'd0, 3'd0, 5'(acc), 7'h13}});
                acc++;
            end
            step();
            if (acc == 4 && c == 3) chk("d4_ready_drop", d4_ready, 0);
        end
        d4_valid = 1'b0;
        step(); step();
        chk("d4_accepts", acc, 4);
        chk("d4_writes", n_w4, 4);
        chk("d4_full", d4_full, 1);
        chk("d4_count", d4_count, 4);
        chk("d4_done", d4_done, 0);
        chk("d4_ready_full", d4_ready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
